// File: rtl/demux_1_n_hs_pkg.sv
// Shared constants and helpers for the 1-to-N handshaked demux.
// Broadcast mode is enabled by defining DEMUX_1_N_BROADCAST_EN.
package demux_1_n_hs_pkg;

  localparam int DEF_N     = 4;
  localparam int DEF_W     = 8;
  localparam int DEF_CNT_W = 8;
  localparam int MAX_N     = 64;

  // Isolates the lowest set bit. Callers cast the result down to their channel count.
  function automatic logic [MAX_N-1:0] lsb_onehot(input logic [MAX_N-1:0] x);
    return x & (~x + 1'b1);
  endfunction

  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One output channel: a single valid/payload register with load and drain.
module demux_out_slot #(
  parameter int P_W = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_load,
  input  logic [P_W-1:0] i_data,
  input  logic           i_ready,
  output logic           o_valid,
  output logic [P_W-1:0] o_data,
  output logic           o_free
);

  logic           v;
  logic [P_W-1:0] d;

  // A reload on the same edge as a drain keeps the slot full with the new beat.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v <= 1'b0;
      d <= '0;
    end else if (i_load) begin
      v <= 1'b1;
      d <= i_data;
    end else if (v && i_ready) begin
      v <= 1'b0;
    end
  end

  assign o_free  = ~v | i_ready;
  assign o_valid = v;
  assign o_data  = d;

endmodule

// File: rtl/demux_1_n_hs.sv
// Registered 1-to-N stream demux with per-channel handshake and a saturating drop counter.
// DEMUX_1_N_BROADCAST_EN: deliver a multi-bit select mask to all selected channels atomically.
module demux_1_n_hs
  import demux_1_n_hs_pkg::*;
#(
  parameter int P_N     = DEF_N,
  parameter int P_W     = DEF_W,
  parameter int P_CNT_W = DEF_CNT_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [P_W-1:0]     i_data,
  input  logic [P_N-1:0]     i_sel_code,
  output logic               o_ready,
  output logic [P_N-1:0]     o_valid,
  output logic [P_N*P_W-1:0] o_data,
  input  logic [P_N-1:0]     i_ready,
  output logic [P_CNT_W-1:0] o_drop_cnt
);

  localparam logic [P_CNT_W-1:0] CNT_MAX = '1;

  logic [P_N-1:0]          tgt;
  logic [P_N-1:0]          chan_free;
  logic [P_N-1:0]          load;
  logic [P_N-1:0][P_W-1:0] slot_data;
  logic                    accept;
  logic [P_CNT_W-1:0]      drop_cnt;

`ifdef DEMUX_1_N_BROADCAST_EN
  assign tgt = i_sel_code;
`else
  assign tgt = P_N'(lsb_onehot(MAX_N'(i_sel_code)));
`endif

  // Untargeted channels count as free, so an empty mask is always ready (and dropped).
  assign o_ready = ~i_rst & (&(chan_free | ~tgt));
  assign accept  = i_valid & o_ready;
  assign load    = {P_N{accept}} & tgt;

  for (genvar k = 0; k < P_N; k++) begin : g_slot
    demux_out_slot #(.P_W(P_W)) u_slot (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (load[k]),
      .i_data  (i_data),
      .i_ready (i_ready[k]),
      .o_valid (o_valid[k]),
      .o_data  (slot_data[k]),
      .o_free  (chan_free[k])
    );
    assign o_data[slice_lo(k, P_W) +: P_W] = slot_data[k];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      drop_cnt <= '0;
    end else if (accept && (tgt == '0) && (drop_cnt != CNT_MAX)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign o_drop_cnt = drop_cnt;

endmodule

// File: tb/tb_demux_1_n_hs.sv
// Directed bench for demux_1_n_hs, with a second instance at P_CNT_W=2 for saturation.
module tb_demux_1_n_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [7:0]  data;
  logic [3:0]  sel;
  logic [3:0]  rdy;
  logic        o_ready, s_ready;
  logic [3:0]  o_valid, s_valid;
  logic [31:0] o_data, s_data;
  logic [7:0]  o_drop;
  logic [1:0]  s_drop;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  demux_1_n_hs #(.P_N(4), .P_W(8), .P_CNT_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .i_sel_code(sel),
    .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data), .i_ready(rdy),
    .o_drop_cnt(o_drop)
  );

  demux_1_n_hs #(.P_N(4), .P_W(8), .P_CNT_W(2)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .i_sel_code(sel),
    .o_ready(s_ready), .o_valid(s_valid), .o_data(s_data), .i_ready(rdy),
    .o_drop_cnt(s_drop)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ch(input int k);
    return o_data[k*8 +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b1; sel = 4'b0100; data = 8'hA5; rdy = 4'b1111;
    tick(); tick();
    check("rst_ready", 32'(o_ready), 32'h0);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_data",  o_data, 32'h0);
    check("rst_drop",  32'(o_drop), 32'h0);

    rst = 1'b0;
    #1 check("first_ready", 32'(o_ready), 32'h1);
    tick();
    check("first_valid", 32'(o_valid), 32'h4);
    check("first_data",  32'(ch(2)), 32'hA5);
    valid = 1'b0;
    tick();
    check("first_drain", 32'(o_valid), 32'h0);

    // Backpressure on channel 1, channel 3 keeps flowing.
    rdy = 4'b1101; valid = 1'b1; sel = 4'b0010; data = 8'h11;
    #1 check("bp_ready_a", 32'(o_ready), 32'h1);
    tick();
    check("bp_ch1_a", 32'(ch(1)), 32'h11);
    sel = 4'b1000; data = 8'h33;
    #1 check("bp_ch3_ready", 32'(o_ready), 32'h1);
    tick();
    check("bp_ch3_valid", 32'(o_valid), 32'hA);
    check("bp_ch3_data",  32'(ch(3)), 32'h33);
    sel = 4'b0010; data = 8'h22;
    #1 check("bp_stall_ready", 32'(o_ready), 32'h0);
    tick();
    check("bp_stall_valid", 32'(o_valid), 32'h2);
    check("bp_stall_hold",  32'(ch(1)), 32'h11);
    rdy = 4'b1111;
    #1 check("bp_release_ready", 32'(o_ready), 32'h1);
    tick();
    check("bp_release_valid", 32'(o_valid), 32'h2);
    check("bp_release_data",  32'(ch(1)), 32'h22);
    valid = 1'b0;
    tick();

    // Zero-mask drops.
    valid = 1'b1; sel = 4'b0000; data = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      #1 check("drop_ready", 32'(o_ready), 32'h1);
      tick();
      check("drop_valid", 32'(o_valid), 32'h0);
    end
    valid = 1'b0;
    check("drop_cnt", 32'(o_drop), 32'h5);
    check("drop_sat", 32'(s_drop), 32'h3);
    tick();

    // Multi-bit mask.
`ifdef DEMUX_1_N_BROADCAST_EN
    rdy = 4'b0111; valid = 1'b1; sel = 4'b1000; data = 8'h77;
    tick();
    check("bc_pre_valid", 32'(o_valid), 32'h8);
    sel = 4'b1010; data = 8'h3C;
    #1 check("bc_stall_ready", 32'(o_ready), 32'h0);
    tick();
    check("bc_stall_valid", 32'(o_valid), 32'h8);
    check("bc_stall_ch3",   32'(ch(3)), 32'h77);
    rdy = 4'b1111;
    #1 check("bc_release_ready", 32'(o_ready), 32'h1);
    tick();
    check("bc_valid", 32'(o_valid), 32'hA);
    check("bc_ch1",   32'(ch(1)), 32'h3C);
    check("bc_ch3",   32'(ch(3)), 32'h3C);
`else
    valid = 1'b1; sel = 4'b1010; data = 8'h3C;
    #1 check("pri_ready", 32'(o_ready), 32'h1);
    tick();
    check("pri_valid", 32'(o_valid), 32'h2);
    check("pri_ch1",   32'(ch(1)), 32'h3C);
`endif
    valid = 1'b0;
    tick();

    // Back-to-back stream into channel 0.
    rdy = 4'b1111; valid = 1'b1; sel = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      data = 8'h50 + 8'(i);
      tick();
      check("stream_valid", 32'(o_valid[0]), 32'h1);
      check("stream_data",  32'(ch(0)), 32'h50 + 32'(i));
    end
    valid = 1'b0;
    tick();
    check("stream_drain", 32'(o_valid), 32'h0);

    // Asynchronous reset while channels 0 and 2 are held.
    rdy = 4'b0000; valid = 1'b1; sel = 4'b0001; data = 8'h0A;
    tick();
    sel = 4'b0100; data = 8'h2A;
    tick();
    valid = 1'b0;
    check("mid_valid", 32'(o_valid), 32'h5);
    check("mid_ch2",   32'(ch(2)), 32'h2A);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(o_valid), 32'h0);
    check("mid_rst_data",  o_data, 32'h0);
    check("mid_rst_ready", 32'(o_ready), 32'h0);
    check("mid_rst_drop",  32'(o_drop), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_valid", 32'(o_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
